// File: rtl/btn_tick_gen_pkg.sv
// rtl/btn_tick_gen_pkg.sv - shared FSM state encoding and default timing constants
package btn_tick_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int DEF_HOLD_CYC     = 50_000_000;
  localparam int DEF_REPEAT_CYC   = 25_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-flop synchronizer, debouncer, press/hold/repeat tick FSM
module btn_channel
  import btn_tick_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic repeat_en,
  input  logic raw,
  output logic tick,
  output logic lvl
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int HC_W = $clog2(max_int(HOLD_CYC, REPEAT_CYC) + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYC - 1);
  localparam logic [HC_W-1:0] HOLD_SAT  = HC_W'(HOLD_CYC);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYC - 1);

  logic            s1;
  logic            s2;
  logic [DB_W-1:0] db_cnt;
  logic            lvl_d;
  logic [1:0]      warm;
  logic            armed;

  btn_state_t      state;
  btn_state_t      state_nxt;
  logic [HC_W-1:0] hc_cnt;
  logic [HC_W-1:0] hc_cnt_nxt;
  logic            tick_nxt;
  logic            rise;
  logic            fall;

  // armed stays low after reset until a genuine low sample is seen, so a
  // button held through reset cannot produce a press tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db_cnt <= '0;
      lvl    <= 1'b0;
      lvl_d  <= 1'b0;
      warm   <= 2'b00;
      armed  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl;
      warm  <= {warm[0], 1'b1};
      if (warm[1] && !s2 && !lvl) begin
        armed <= 1'b1;
      end
      if (s2 == lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        lvl    <= ~lvl;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign rise = lvl & ~lvl_d & armed;
  assign fall = ~lvl & lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      hc_cnt <= '0;
      tick   <= 1'b0;
    end else begin
      state  <= state_nxt;
      hc_cnt <= hc_cnt_nxt;
      tick   <= tick_nxt;
    end
  end

  // HOLD_SAT is out of reach of normal counting, so a saturated hold never
  // restarts repeating even if repeat_en comes back before release.
  always_comb begin
    state_nxt  = state;
    hc_cnt_nxt = hc_cnt;
    tick_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          tick_nxt   = 1'b1;
          state_nxt  = ST_HOLD;
          hc_cnt_nxt = '0;
        end
      end
      ST_HOLD: begin
        if (fall) begin
          state_nxt  = ST_IDLE;
          hc_cnt_nxt = '0;
        end else if (hc_cnt == HOLD_SAT) begin
          hc_cnt_nxt = HOLD_SAT;
        end else if (hc_cnt == HOLD_LAST) begin
          if (repeat_en) begin
            tick_nxt   = 1'b1;
            state_nxt  = ST_REPEAT;
            hc_cnt_nxt = '0;
          end else begin
            hc_cnt_nxt = HOLD_SAT;
          end
        end else begin
          hc_cnt_nxt = hc_cnt + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          state_nxt  = ST_IDLE;
          hc_cnt_nxt = '0;
        end else if (!repeat_en) begin
          state_nxt  = ST_HOLD;
          hc_cnt_nxt = HOLD_SAT;
        end else if (hc_cnt == REP_LAST) begin
          tick_nxt   = 1'b1;
          hc_cnt_nxt = '0;
        end else begin
          hc_cnt_nxt = hc_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        hc_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_tick_gen.sv
// rtl/btn_tick_gen.sv - hour/minute set-button conditioning, two independent channels
module btn_tick_gen
  import btn_tick_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic repeat_en,
  input  logic btn_hr_raw,
  input  logic btn_min_raw,
  output logic tick_hr,
  output logic tick_min,
  output logic btn_hr_lvl,
  output logic btn_min_lvl
);

  btn_channel #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC)
  ) u_hr (
    .clk       (clk_100MHz),
    .rst_n     (reset),
    .repeat_en (repeat_en),
    .raw       (btn_hr_raw),
    .tick      (tick_hr),
    .lvl       (btn_hr_lvl)
  );

  btn_channel #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC)
  ) u_min (
    .clk       (clk_100MHz),
    .rst_n     (reset),
    .repeat_en (repeat_en),
    .raw       (btn_min_raw),
    .tick      (tick_min),
    .lvl       (btn_min_lvl)
  );

endmodule
